// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-station result FIFOs feeding one round-robin granted CDB.
// Optional build macro CDB_ARB_PRIO_EN gives source 1 (MUL) fixed priority over the rotation.
module cdb_arbiter #(
    parameter int unsigned N_SRC      = 3,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned TAG_W      = 6,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                       in_clock,
    input  logic                       in_reset,
    input  logic                       in_flush,
    input  logic [N_SRC-1:0]           in_src_valid,
    input  logic [N_SRC*TAG_W-1:0]     in_src_tag,
    input  logic [N_SRC*DATA_W-1:0]    in_src_data,
    output logic [N_SRC-1:0]           out_src_ready,
    output logic                       out_CDB_is_cast,
    output logic [TAG_W-1:0]           out_CDB_tag,
    output logic [DATA_W-1:0]          out_CDB_data,
    output logic [$clog2(N_SRC)-1:0]   out_CDB_src,
    output logic                       out_drop
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SRC_W = $clog2(N_SRC);
    localparam int unsigned ENT_W = TAG_W + DATA_W;
    localparam logic [TAG_W-1:0] TAG_INVALID = '1;
`ifdef CDB_ARB_PRIO_EN
    localparam int unsigned PRIO_SRC = 1;
`endif

    logic [ENT_W-1:0]  mem_q    [N_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [N_SRC];
    logic [PTR_W-1:0]  wr_ptr_d [N_SRC];
    logic [PTR_W-1:0]  rd_ptr_q [N_SRC];
    logic [PTR_W-1:0]  rd_ptr_d [N_SRC];
    logic [CNT_W-1:0]  cnt_q    [N_SRC];
    logic [CNT_W-1:0]  cnt_d    [N_SRC];
    logic [SRC_W-1:0]  rr_q, rr_d;

    logic              cast_q, cast_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SRC_W-1:0]  src_q, src_d;
    logic              drop_q, drop_d;

    logic [N_SRC-1:0]  full, nonempty, accept, push, pop, offer_invalid;
    logic              grant_vld;
    logic [SRC_W-1:0]  grant_idx;
    logic [SRC_W-1:0]  cand_idx;
    logic [ENT_W-1:0]  head_ent;

    // Ready is a function of the registered count only, so a full FIFO stays
    // not-ready even in the cycle its head is being granted.
    always_comb begin
        full          = '0;
        nonempty      = '0;
        accept        = '0;
        push          = '0;
        offer_invalid = '0;
        out_src_ready = '0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            full[k]          = (cnt_q[k] == CNT_W'(FIFO_DEPTH));
            nonempty[k]      = (cnt_q[k] != '0);
            out_src_ready[k] = !full[k] && !in_reset;
            accept[k]        = in_src_valid[k] && out_src_ready[k];
            offer_invalid[k] = accept[k] && (in_src_tag[k*TAG_W +: TAG_W] == TAG_INVALID);
            push[k]          = accept[k] && !in_flush && !offer_invalid[k];
        end
    end

`ifdef CDB_ARB_PRIO_EN
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand_idx  = '0;
        if (nonempty[PRIO_SRC]) begin
            grant_vld = 1'b1;
            grant_idx = SRC_W'(PRIO_SRC);
        end else begin
            for (int unsigned i = 0; i < N_SRC; i++) begin
                cand_idx = SRC_W'((32'(rr_q) + i) % N_SRC);
                if (!grant_vld && nonempty[cand_idx] && (cand_idx != SRC_W'(PRIO_SRC))) begin
                    grant_vld = 1'b1;
                    grant_idx = cand_idx;
                end
            end
        end
    end
`else
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand_idx  = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            cand_idx = SRC_W'((32'(rr_q) + i) % N_SRC);
            if (!grant_vld && nonempty[cand_idx]) begin
                grant_vld = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end
`endif

    assign head_ent = mem_q[grant_idx][rd_ptr_q[grant_idx]];

    always_comb begin
        pop    = '0;
        rr_d   = rr_q;
        cast_d = 1'b0;
        tag_d  = tag_q;
        data_d = data_q;
        src_d  = src_q;
        drop_d = (|offer_invalid) && !in_flush;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            pop[k] = grant_vld && !in_flush && (grant_idx == SRC_W'(k));
        end
        if (grant_vld && !in_flush) begin
            cast_d = 1'b1;
            tag_d  = head_ent[ENT_W-1 -: TAG_W];
            data_d = head_ent[DATA_W-1:0];
            src_d  = grant_idx;
`ifdef CDB_ARB_PRIO_EN
            if (grant_idx != SRC_W'(PRIO_SRC))
`endif
                rr_d = (grant_idx == SRC_W'(N_SRC - 1)) ? '0 : grant_idx + 1'b1;
        end
        if (in_flush) begin
            rr_d = '0;
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < N_SRC; k++) begin
            wr_ptr_d[k] = wr_ptr_q[k];
            rd_ptr_d[k] = rd_ptr_q[k];
            cnt_d[k]    = cnt_q[k];
            if (in_flush) begin
                wr_ptr_d[k] = '0;
                rd_ptr_d[k] = '0;
                cnt_d[k]    = '0;
            end else begin
                if (push[k]) wr_ptr_d[k] = wr_ptr_q[k] + 1'b1;
                if (pop[k])  rd_ptr_d[k] = rd_ptr_q[k] + 1'b1;
                cnt_d[k] = cnt_q[k] + CNT_W'(push[k]) - CNT_W'(pop[k]);
            end
        end
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            for (int unsigned k = 0; k < N_SRC; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
            rr_q   <= '0;
            cast_q <= 1'b0;
            tag_q  <= '0;
            data_q <= '0;
            src_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < N_SRC; k++) begin
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
                cnt_q[k]    <= cnt_d[k];
            end
            rr_q   <= rr_d;
            cast_q <= cast_d;
            tag_q  <= tag_d;
            data_q <= data_d;
            src_q  <= src_d;
            drop_q <= drop_d;
        end
    end

    always_ff @(posedge in_clock) begin
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (push[k]) begin
                mem_q[k][wr_ptr_q[k]] <= {in_src_tag[k*TAG_W +: TAG_W], in_src_data[k*DATA_W +: DATA_W]};
            end
        end
    end

    assign out_CDB_is_cast = cast_q;
    assign out_CDB_tag     = tag_q;
    assign out_CDB_data    = data_q;
    assign out_CDB_src     = src_q;
    assign out_drop        = drop_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: per-source result queues model the buffering and grant rules.
module tb_cdb_arbiter;

    localparam int N  = 3;
    localparam int D  = 2;
    localparam int TW = 6;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [N-1:0]    valid;
    logic [N*TW-1:0] tag;
    logic [N*DW-1:0] data;
    logic [N-1:0]    ready;
    logic            cast;
    logic [TW-1:0]   cdb_tag;
    logic [DW-1:0]   cdb_data;
    logic [1:0]      cdb_src;
    logic            drop;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [TW-1:0] t;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq[N][$];
    int            rr;
    logic          e_cast;
    logic [TW-1:0] e_tag;
    logic [DW-1:0] e_data;
    logic [1:0]    e_src;
    logic          e_drop;

    cdb_arbiter #(.N_SRC(N), .FIFO_DEPTH(D), .TAG_W(TW), .DATA_W(DW)) dut (
        .in_clock        (clk),
        .in_reset        (rst),
        .in_flush        (flush),
        .in_src_valid    (valid),
        .in_src_tag      (tag),
        .in_src_data     (data),
        .out_src_ready   (ready),
        .out_CDB_is_cast (cast),
        .out_CDB_tag     (cdb_tag),
        .out_CDB_data    (cdb_data),
        .out_CDB_src     (cdb_src),
        .out_drop        (drop)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) r[k] = (mq[k].size() < D) && !rst;
        return r;
    endfunction

    // Reference behaviour of one clock edge, from the inputs held across it.
    task automatic model_edge();
        int   sz[N];
        int   g;
        int   c;
        ent_t e;
        for (int k = 0; k < N; k++) sz[k] = mq[k].size();
        if (rst || flush) begin
            for (int k = 0; k < N; k++) mq[k].delete();
            rr     = 0;
            e_cast = 1'b0;
            e_drop = 1'b0;
            if (rst) begin
                e_tag  = '0;
                e_data = '0;
                e_src  = '0;
            end
            return;
        end
        g = -1;
`ifdef CDB_ARB_PRIO_EN
        if (sz[1] > 0) g = 1;
        else
            for (int i = 0; i < N; i++) begin
                c = (rr + i) % N;
                if (g < 0 && c != 1 && sz[c] > 0) g = c;
            end
`else
        for (int i = 0; i < N; i++) begin
            c = (rr + i) % N;
            if (g < 0 && sz[c] > 0) g = c;
        end
`endif
        e_cast = (g >= 0);
        if (g >= 0) begin
            e      = mq[g].pop_front();
            e_tag  = e.t;
            e_data = e.d;
            e_src  = 2'(g);
`ifdef CDB_ARB_PRIO_EN
            if (g != 1)
`endif
                rr = (g + 1) % N;
        end
        e_drop = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (valid[k] && sz[k] < D) begin
                if (tag[k*TW +: TW] == '1) e_drop = 1'b1;
                else mq[k].push_back('{t: tag[k*TW +: TW], d: data[k*DW +: DW]});
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; valid = '0; tag = '0; data = '0;
        repeat (3) tick();
        total++;
        if ({cast, cdb_tag, cdb_data, cdb_src, drop, ready} !== '0) begin
            bad++;
            $display("FAIL reset_state got=%h want=0", {cast, cdb_tag, cdb_data, cdb_src, drop, ready});
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (cast !== 1'b0 || ready !== 3'b111 || drop !== 1'b0) begin
                bad++;
                $display("FAIL idle_after_reset cycle=%0d got cast=%b ready=%b drop=%b want 0/111/0",
                         i, cast, ready, drop);
            end
        end
    endtask

    task automatic test_single();
        valid = 3'b010;
        tag[1*TW +: TW]  = 6'h05;
        data[1*DW +: DW] = 32'h0000_0C8A;
        tick();
        valid = '0;
        total++;
        if (cast !== 1'b0) begin
            bad++;
            $display("FAIL single_edgeE got cast=%b want 0", cast);
        end
        tick();
        total++;
        if ({cast, cdb_tag, cdb_data, cdb_src} !== {1'b1, 6'h05, 32'h0000_0C8A, 2'd1}) begin
            bad++;
            $display("FAIL single_bcast got cast=%b tag=%h data=%h src=%0d want 1/05/00000c8a/1",
                     cast, cdb_tag, cdb_data, cdb_src);
        end
        tick();
        total++;
        if (cast !== 1'b0 || cdb_tag !== 6'h05) begin
            bad++;
            $display("FAIL single_after got cast=%b tag=%h want 0/05", cast, cdb_tag);
        end
    endtask

    task automatic test_back_to_back();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            valid = 3'b111;
            for (int k = 0; k < N; k++) begin
                tag[k*TW +: TW]  = 6'(c * 3 + k);
                data[k*DW +: DW] = $urandom();
            end
            tick();
            total++;
            if ({cast, cdb_tag, cdb_data, cdb_src, drop, ready} !==
                {e_cast, e_tag, e_data, e_src, e_drop, exp_ready()}) begin
                bad++;
                $display("FAIL backlog_model c=%0d got cast=%b tag=%h data=%h src=%0d ready=%b want %b/%h/%h/%0d/%b",
                         c, cast, cdb_tag, cdb_data, cdb_src, ready, e_cast, e_tag, e_data, e_src, exp_ready());
            end
            if (c >= 1) begin
                total++;
                if (cast !== 1'b1 || cdb_src !== 2'((c - 1) % 3)) begin
                    bad++;
                    $display("FAIL backlog_rotation c=%0d got cast=%b src=%0d want 1/%0d",
                             c, cast, cdb_src, (c - 1) % 3);
                end
            end
        end
        valid = '0;
        for (int c = 0; c < 8; c++) begin
            tick();
            total++;
            if ({cast, cdb_tag, cdb_data, cdb_src, ready} !== {e_cast, e_tag, e_data, e_src, exp_ready()}) begin
                bad++;
                $display("FAIL backlog_drain c=%0d got cast=%b tag=%h src=%0d want %b/%h/%0d",
                         c, cast, cdb_tag, cdb_src, e_cast, e_tag, e_src);
            end
        end
    endtask

    task automatic test_drop();
        valid = 3'b001;
        tag[0 +: TW] = 6'h3F;
        tick();
        valid = '0;
        total++;
        if (drop !== 1'b1 || cast !== 1'b0) begin
            bad++;
            $display("FAIL drop_pulse got drop=%b cast=%b want 1/0", drop, cast);
        end
        tick();
        total++;
        if (drop !== 1'b0 || cast !== 1'b0) begin
            bad++;
            $display("FAIL drop_clear got drop=%b cast=%b want 0/0", drop, cast);
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 4; c++) begin
            valid = 3'b111;
            for (int k = 0; k < N; k++) tag[k*TW +: TW] = 6'(40 + c * 3 + k);
            tick();
            total++;
            if ({cast, cdb_tag, cdb_src, ready} !== {e_cast, e_tag, e_src, exp_ready()}) begin
                bad++;
                $display("FAIL flush_fill c=%0d got cast=%b tag=%h src=%0d ready=%b want %b/%h/%0d/%b",
                         c, cast, cdb_tag, cdb_src, ready, e_cast, e_tag, e_src, exp_ready());
            end
        end
        flush = 1'b1;
        valid = 3'b100;
        tag[2*TW +: TW] = 6'h2A;
        tick();
        flush = 1'b0;
        valid = '0;
        total++;
        if (cast !== 1'b0 || ready !== 3'b111) begin
            bad++;
            $display("FAIL flush_next got cast=%b ready=%b want 0/111", cast, ready);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (cast !== 1'b0) begin
                bad++;
                $display("FAIL flush_no_bcast c=%0d got cast=%b tag=%h want cast 0", c, cast, cdb_tag);
            end
        end
    endtask

`ifdef CDB_ARB_PRIO_EN
    task automatic test_prio();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            valid = 3'b011;
            tag[0 +: TW]  = 6'(c);
            tag[TW +: TW] = 6'(20 + c);
            tick();
            total++;
            if (cast === 1'b1 && cdb_src !== 2'd1) begin
                bad++;
                $display("FAIL prio_mul_first c=%0d got src=%0d want 1", c, cdb_src);
            end
        end
        valid = '0;
        for (int c = 0; c < 6; c++) begin
            tick();
            total++;
            if ({cast, cdb_tag, cdb_src} !== {e_cast, e_tag, e_src}) begin
                bad++;
                $display("FAIL prio_drain c=%0d got cast=%b tag=%h src=%0d want %b/%h/%0d",
                         c, cast, cdb_tag, cdb_src, e_cast, e_tag, e_src);
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst   = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 24) == 0);
            valid = 3'($urandom());
            for (int k = 0; k < N; k++) begin
                tag[k*TW +: TW]  = ($urandom_range(0, 7) == 0) ? 6'h3F : 6'($urandom_range(0, 62));
                data[k*DW +: DW] = $urandom();
            end
            tick();
            total++;
            if ({cast, cdb_tag, cdb_data, cdb_src, drop, ready} !==
                {e_cast, e_tag, e_data, e_src, e_drop, exp_ready()}) begin
                bad++;
                $display("FAIL random c=%0d got cast=%b tag=%h data=%h src=%0d drop=%b ready=%b want %b/%h/%h/%0d/%b/%b",
                         c, cast, cdb_tag, cdb_data, cdb_src, drop, ready,
                         e_cast, e_tag, e_data, e_src, e_drop, exp_ready());
            end
        end
        rst = 1'b0; flush = 1'b0; valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; valid = '0; tag = '0; data = '0;
        rr = 0; e_cast = 1'b0; e_tag = '0; e_data = '0; e_src = '0; e_drop = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_drop();
        test_flush();
`ifdef CDB_ARB_PRIO_EN
        test_prio();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
